ball_mover: RTL and testbench

BALL_MOVER -- requirements
Module: ball_mover

---
 rtl/ball_mover.sv | 131 +++++++++++++
 tb/tb_ball_mover.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ball_mover.sv
// Bouncing-ball motion engine: spawns at a fixed point, falls under gravity,
// bounces off the floor and side walls once per frame, and freezes when popped.
module ball_mover #(
  parameter int INITIAL_X              = 280,
  parameter int INITIAL_Y              = 185,
  parameter int INITIAL_X_SPEED        = 64,
  parameter int INITIAL_Y_SPEED        = 0,
  parameter int GRAVITY                = 8,
  parameter int MAX_Y_SPEED            = 400,
  parameter int BOUNCE_SPEED           = 320,
  parameter int BALL_SIZE              = 32,
  parameter int FRAME_W                = 639,
  parameter int FRAME_H                = 479,
  parameter int FIXED_POINT_MULTIPLIER = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               available,
  input  logic               hit,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               ballVisible,
  output logic               popped,
  output logic [1:0]         debugState
);

  localparam int SHIFT = $clog2(FIXED_POINT_MULTIPLIER);

  localparam logic signed [31:0] SPAWN_X       = INITIAL_X * FIXED_POINT_MULTIPLIER;
  localparam logic signed [31:0] SPAWN_Y       = INITIAL_Y * FIXED_POINT_MULTIPLIER;
  localparam logic signed [31:0] SPAWN_XS      = INITIAL_X_SPEED;
  localparam logic signed [31:0] SPAWN_YS      = INITIAL_Y_SPEED;
  localparam logic signed [31:0] GRAVITY_S     = GRAVITY;
  localparam logic signed [31:0] MAX_YS        = MAX_Y_SPEED;
  localparam logic signed [31:0] BOUNCE_S      = BOUNCE_SPEED;
  localparam logic signed [31:0] SIZE_S        = BALL_SIZE;
  localparam logic signed [31:0] FRAME_W_S     = FRAME_W;
  localparam logic signed [31:0] FRAME_H_S     = FRAME_H;
  localparam logic signed [31:0] FLOOR_Y       = (FRAME_H - BALL_SIZE) * FIXED_POINT_MULTIPLIER;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DEAD   = 2'd2
  } state_t;

  state_t             state, stateN;
  logic signed [31:0] xPos, yPos, xSpeed, ySpeed;
  logic signed [31:0] xPosN, yPosN, xSpeedN, ySpeedN;

  // Per-frame kinematics, evaluated every cycle and applied only on an update.
  logic signed [31:0] xPix, yPix, ySpeedInc, ySpeedUpd, xSpeedUpd, yBase;
  logic               floorHit, rightHit, leftHit;

  always_comb begin
    xPix      = xPos >>> SHIFT;
    yPix      = yPos >>> SHIFT;
    floorHit  = ((yPix + SIZE_S) >= FRAME_H_S) && (ySpeed > 0);
    rightHit  = ((xPix + SIZE_S) >= FRAME_W_S) && (xSpeed > 0);
    leftHit   = (xPos <= 0) && (xSpeed < 0);
    ySpeedInc = ySpeed + GRAVITY_S;
    if (floorHit) begin
      ySpeedUpd = -BOUNCE_S;
      yBase     = FLOOR_Y;
    end else begin
      ySpeedUpd = (ySpeedInc > MAX_YS) ? MAX_YS : ySpeedInc;
      yBase     = yPos;
    end
    xSpeedUpd = (rightHit || leftHit) ? -xSpeed : xSpeed;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      xPos   <= SPAWN_X;
      yPos   <= SPAWN_Y;
      xSpeed <= SPAWN_XS;
      ySpeed <= SPAWN_YS;
    end else begin
      state  <= stateN;
      xPos   <= xPosN;
      yPos   <= yPosN;
      xSpeed <= xSpeedN;
      ySpeed <= ySpeedN;
    end
  end

  // Priority inside MOVING: hit, then loss of the slot, then the frame update.
  always_comb begin
    stateN  = state;
    xPosN   = xPos;
    yPosN   = yPos;
    xSpeedN = xSpeed;
    ySpeedN = ySpeed;
    case (state)
      IDLE: begin
        xPosN   = SPAWN_X;
        yPosN   = SPAWN_Y;
        xSpeedN = SPAWN_XS;
        ySpeedN = SPAWN_YS;
        if (available && startOfFrame) stateN = MOVING;
      end
      MOVING: begin
        if (hit) begin
          stateN = DEAD;
        end else if (!available) begin
          stateN  = IDLE;
          xPosN   = SPAWN_X;
          yPosN   = SPAWN_Y;
          xSpeedN = SPAWN_XS;
          ySpeedN = SPAWN_YS;
        end else if (startOfFrame) begin
          xSpeedN = xSpeedUpd;
          ySpeedN = ySpeedUpd;
          xPosN   = xPos + xSpeedUpd;
          yPosN   = yBase + ySpeedUpd;
        end
      end
      DEAD:    stateN = DEAD;
      default: stateN = IDLE;
    endcase
  end

  assign topLeftX    = xPos[SHIFT+10:SHIFT];
  assign topLeftY    = yPos[SHIFT+10:SHIFT];
  assign ballVisible = (state == MOVING);
  assign popped      = (state == MOVING) && hit;
  assign debugState  = state;

endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover: several parameterised instances share one
// stimulus stream; each scenario checks the instance whose spawn exercises it.
module tb_ball_mover;

  logic clk = 1'b0;
  logic reset, startOfFrame, available, hit;

  logic signed [10:0] tlx [5];
  logic signed [10:0] tly [5];
  logic               vis [5];
  logic               pop [5];
  logic [1:0]         dst [5];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // dut0: defaults
  ball_mover dut0 (.clk(clk), .reset(reset), .startOfFrame(startOfFrame), .available(available),
    .hit(hit), .topLeftX(tlx[0]), .topLeftY(tly[0]), .ballVisible(vis[0]), .popped(pop[0]),
    .debugState(dst[0]));
  // dut1: spawns on the floor moving down
  ball_mover #(.INITIAL_Y(447), .INITIAL_Y_SPEED(64)) dut1 (.clk(clk), .reset(reset),
    .startOfFrame(startOfFrame), .available(available), .hit(hit), .topLeftX(tlx[1]),
    .topLeftY(tly[1]), .ballVisible(vis[1]), .popped(pop[1]), .debugState(dst[1]));
  // dut2: spawns touching the right wall
  ball_mover #(.INITIAL_X(607), .INITIAL_X_SPEED(64)) dut2 (.clk(clk), .reset(reset),
    .startOfFrame(startOfFrame), .available(available), .hit(hit), .topLeftX(tlx[2]),
    .topLeftY(tly[2]), .ballVisible(vis[2]), .popped(pop[2]), .debugState(dst[2]));
  // dut3: spawns on the left wall moving left
  ball_mover #(.INITIAL_X(0), .INITIAL_X_SPEED(-64)) dut3 (.clk(clk), .reset(reset),
    .startOfFrame(startOfFrame), .available(available), .hit(hit), .topLeftX(tlx[3]),
    .topLeftY(tly[3]), .ballVisible(vis[3]), .popped(pop[3]), .debugState(dst[3]));
  // dut4: deep floor so a long fall saturates without bouncing
  ball_mover #(.FRAME_H(1000)) dut4 (.clk(clk), .reset(reset),
    .startOfFrame(startOfFrame), .available(available), .hit(hit), .topLeftX(tlx[4]),
    .topLeftY(tly[4]), .ballVisible(vis[4]), .popped(pop[4]), .debugState(dst[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One startOfFrame pulse followed by a quiet cycle.
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  int exp_ys;

  initial begin
    reset        = 1'b1;
    startOfFrame = 1'b0;
    available    = 1'b0;
    hit          = 1'b0;
    tick();
    check("rst_x",     32'(tlx[0]), 280);
    check("rst_y",     32'(tly[0]), 185);
    check("rst_vis",   32'(vis[0]), 0);
    check("rst_pop",   32'(pop[0]), 0);
    check("rst_state", 32'(dst[0]), 0);

    reset     = 1'b0;
    available = 1'b1;
    tick();
    frame();
    check("enter_state", 32'(dst[0]), 1);
    check("enter_vis",   32'(vis[0]), 1);
    check("enter_x",     32'(tlx[0]), 280);
    check("enter_y",     32'(tly[0]), 185);

    frame();
    check("f1_x",    32'(tlx[0]), 281);
    check("f1_y",    32'(tly[0]), 185);
    check("f1_xpos", dut0.xPos, 17984);
    check("f1_ypos", dut0.yPos, 11848);
    check("f1_vis",  32'(vis[0]), 1);
    check("floor_ys",   dut1.ySpeed, -320);
    check("floor_ypos", dut1.yPos, 28288);
    check("floor_y",    32'(tly[1]), 442);
    check("rwall_xs",   dut2.xSpeed, -64);
    check("rwall_x",    32'(tlx[2]), 606);
    check("lwall_xs",   dut3.xSpeed, 64);
    check("lwall_x",    32'(tlx[3]), 1);

    repeat (3) tick();
    check("hold_x", 32'(tlx[0]), 281);
    check("hold_y", 32'(dut0.yPos), 11848);

    // Losing the slot beats a simultaneous frame update.
    available    = 1'b0;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    check("drop_state", 32'(dst[0]), 0);
    check("drop_x",     32'(tlx[0]), 280);
    check("drop_y",     32'(tly[0]), 185);
    check("drop_vis",   32'(vis[0]), 0);
    check("drop_ys",    dut0.ySpeed, 0);

    available = 1'b1;
    frame();
    frame();
    check("re_x", 32'(tlx[0]), 281);

    // Hit together with a frame pulse: pop wins, position frozen.
    hit          = 1'b1;
    startOfFrame = 1'b1;
    #1;
    check("hit_pop", 32'(pop[0]), 1);
    tick();
    hit          = 1'b0;
    startOfFrame = 1'b0;
    check("dead_pop",   32'(pop[0]), 0);
    check("dead_state", 32'(dst[0]), 2);
    check("dead_vis",   32'(vis[0]), 0);
    check("dead_x",     32'(tlx[0]), 281);
    check("dead_y",     32'(tly[0]), 185);

    available = 1'b0;
    tick();
    available = 1'b1;
    frame();
    hit = 1'b1;
    #1;
    check("dead_hit_pop", 32'(pop[0]), 0);
    tick();
    hit = 1'b0;
    frame();
    check("dead_hold_state", 32'(dst[0]), 2);
    check("dead_hold_x",     32'(tlx[0]), 281);
    check("dead_hold_y",     32'(dut0.yPos), 11848);

    // Asynchronous reset mid-flight while a pop pulse is showing.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    frame();
    repeat (3) frame();
    check("fly_x", 32'(tlx[0]), 283);
    #2;
    hit = 1'b1;
    #1;
    check("fly_pop", 32'(pop[0]), 1);
    reset = 1'b1;
    #1;
    check("arst_x",     32'(tlx[0]), 280);
    check("arst_y",     32'(tly[0]), 185);
    check("arst_vis",   32'(vis[0]), 0);
    check("arst_pop",   32'(pop[0]), 0);
    check("arst_state", 32'(dst[0]), 0);
    @(negedge clk);
    hit   = 1'b0;
    reset = 1'b0;
    tick();

    // Long fall: speed climbs by GRAVITY each frame and clamps at MAX_Y_SPEED.
    frame();
    for (int k = 1; k <= 100; k++) begin
      frame();
      exp_ys = (8 * k > 400) ? 400 : 8 * k;
      check($sformatf("sat_ys_%0d", k), dut4.ySpeed, exp_ys);
    end
    check("sat_ypos", dut4.yPos, 42040);
    check("sat_y",    32'(tly[4]), 656);
    check("sat_vis",  32'(vis[4]), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
